// File: rtl/kyber_ld_pkg.sv
// Shared types and constants for the Kyber input-BRAM loader.
// Defines the operand region map (base line and length per region) and the loader FSM states.
package kyber_ld_pkg;

    typedef enum logic [1:0] {
        REG_PK = 2'd0,
        REG_MR = 2'd1,
        REG_SK = 2'd2,
        REG_C  = 2'd3
    } region_e;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StFlush,
        StDone
    } ld_state_e;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned WORDS_PER_LINE = 4;

    localparam logic [7:0] PK_BASE = 8'd0;
    localparam logic [7:0] PK_LEN  = 8'd50;
    localparam logic [7:0] MR_BASE = 8'd50;
    localparam logic [7:0] MR_LEN  = 8'd4;
    localparam logic [7:0] SK_BASE = 8'd54;
    localparam logic [7:0] SK_LEN  = 8'd48;
    localparam logic [7:0] C_BASE  = 8'd102;
    localparam logic [7:0] C_LEN   = 8'd48;

    function automatic logic [7:0] region_base(region_e r);
        logic [7:0] b;
        unique case (r)
            REG_PK:  b = PK_BASE;
            REG_MR:  b = MR_BASE;
            REG_SK:  b = SK_BASE;
            default: b = C_BASE;
        endcase
        return b;
    endfunction

    // Line offset of the final line in a region.
    function automatic logic [7:0] region_last(region_e r);
        logic [7:0] l;
        unique case (r)
            REG_PK:  l = PK_LEN - 8'd1;
            REG_MR:  l = MR_LEN - 8'd1;
            REG_SK:  l = SK_LEN - 8'd1;
            default: l = C_LEN - 8'd1;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/kyber_word_packer.sv
// Packs 32-bit stream words into a 128-bit line, word0 in the LSBs.
// Pulses line_ready_o on the 4th word or on an early last word; unfilled words read as zero.
module kyber_word_packer
    import kyber_ld_pkg::*;
#(
    parameter int unsigned DATA_W = 128
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              accept_i,
    input  logic              last_i,
    input  logic [31:0]       word_i,
    output logic              line_ready_o,
    output logic [DATA_W-1:0] line_o,
    output logic [1:0]        word_idx_o
);

    logic [DATA_W-1:0] line_q;
    logic [1:0]        idx_q;

    // The line as it will look once the current word is inserted.
    always_comb begin
        line_o = line_q;
        line_o[{idx_q, 5'b00000} +: WORD_W] = word_i;
    end

    assign line_ready_o = accept_i & (last_i | (idx_q == 2'd3));
    assign word_idx_o   = idx_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            line_q <= '0;
            idx_q  <= '0;
        end else if (clear_i) begin
            line_q <= '0;
            idx_q  <= '0;
        end else if (accept_i) begin
            if (line_ready_o) begin
                line_q <= '0;
                idx_q  <= '0;
            end else begin
                line_q <= line_o;
                idx_q  <= idx_q + 2'd1;
            end
        end
    end

endmodule

// File: rtl/kyber_bram_loader.sv
// Streams host words into one fixed region of the Kyber input BRAM, 4 words per line.
// Optional checksum output enabled by defining KYBER_LOADER_CKSUM_EN.
module kyber_bram_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 128
) (
    input  logic              reg_clk,
    input  logic              reg_rst_n,
    input  logic              start,
    input  logic [1:0]        sel,
    input  logic [31:0]       s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic [ADDR_W-1:0] addr_ld_br,
    output logic              en_ld_br,
    output logic [15:0]       we_ld_br,
    output logic [DATA_W-1:0] wrdata_ld_br,
    output logic              busy,
    output logic              done,
    output logic              err_short,
    output logic              err_nolast
`ifdef KYBER_LOADER_CKSUM_EN
    ,
    output logic [31:0]       cksum
`endif
);

    import kyber_ld_pkg::*;

    ld_state_e         state_q;
    region_e           region_q;
    logic [ADDR_W-1:0] line_cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wrdata_q;
    logic              en_q;
    logic [15:0]       we_q;
    logic              done_q;
    logic              err_short_q;
    logic              err_nolast_q;

    logic              accept;
    logic              start_take;
    logic              fill_last;
    logic              line_ready;
    logic [DATA_W-1:0] line_data;
    logic [1:0]        word_idx;

    assign s_ready    = (state_q == StLoad);
    assign busy       = (state_q == StLoad) | (state_q == StFlush);
    assign accept     = s_valid & s_ready;
    assign start_take = start & ((state_q == StIdle) | (state_q == StDone));
    // Fourth word of the region's final line: the region is exactly full.
    assign fill_last  = accept & (word_idx == 2'd3) &
                        (line_cnt_q == ADDR_W'(region_last(region_q)));

    assign addr_ld_br   = addr_q;
    assign en_ld_br     = en_q;
    assign we_ld_br     = we_q;
    assign wrdata_ld_br = wrdata_q;
    assign done         = done_q;
    assign err_short    = err_short_q;
    assign err_nolast   = err_nolast_q;

`ifdef KYBER_LOADER_CKSUM_EN
    logic [31:0] cksum_q;
    assign cksum = cksum_q;
`endif

    kyber_word_packer #(
        .DATA_W(DATA_W)
    ) u_packer (
        .clk_i       (reg_clk),
        .rst_ni      (reg_rst_n),
        .clear_i     (start_take),
        .accept_i    (accept),
        .last_i      (s_last),
        .word_i      (s_data),
        .line_ready_o(line_ready),
        .line_o      (line_data),
        .word_idx_o  (word_idx)
    );

    always_ff @(posedge reg_clk or negedge reg_rst_n) begin
        if (!reg_rst_n) begin
            state_q      <= StIdle;
            region_q     <= REG_PK;
            line_cnt_q   <= '0;
            addr_q       <= '0;
            wrdata_q     <= '0;
            en_q         <= 1'b0;
            we_q         <= '0;
            done_q       <= 1'b0;
            err_short_q  <= 1'b0;
            err_nolast_q <= 1'b0;
`ifdef KYBER_LOADER_CKSUM_EN
            cksum_q      <= '0;
`endif
        end else begin
            en_q <= 1'b0;
            we_q <= '0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        region_q     <= region_e'(sel);
                        line_cnt_q   <= '0;
                        done_q       <= 1'b0;
                        err_short_q  <= 1'b0;
                        err_nolast_q <= 1'b0;
`ifdef KYBER_LOADER_CKSUM_EN
                        cksum_q      <= '0;
`endif
                        state_q      <= StLoad;
                    end
                end
                StLoad: begin
                    if (accept) begin
`ifdef KYBER_LOADER_CKSUM_EN
                        cksum_q <= cksum_q ^ s_data;
`endif
                        if (line_ready) begin
                            en_q       <= 1'b1;
                            we_q       <= 16'hFFFF;
                            addr_q     <= ADDR_W'(region_base(region_q)) + line_cnt_q;
                            wrdata_q   <= line_data;
                            line_cnt_q <= line_cnt_q + 1'b1;
                        end
                        if (fill_last) begin
                            done_q       <= 1'b1;
                            err_nolast_q <= ~s_last;
                            state_q      <= StDone;
                        end else if (s_last) begin
                            // Partial line is written on this edge; FLUSH only closes out.
                            state_q <= StFlush;
                        end
                    end
                end
                StFlush: begin
                    err_short_q <= 1'b1;
                    done_q      <= 1'b1;
                    state_q     <= StDone;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
